// File: rtl/mem_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memctl_pkg
// Brief   : Shared states, access-size and direction constants for the
//           memory access controller.
// Revision: 1.0 - initial release
// ============================================================================
package memctl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ENABLE    = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int DEFAULT_MEM_BYTES = 512;

    // Number of bytes touched by one access.
    function automatic logic [2:0] access_size(input logic byte_acc);
        return (byte_acc == SIZE_BYTE) ? 3'd1 : 3'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_controller_if
// Brief   : Request/response and RAM-side bus of the memory access controller.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_rw;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_enable;
    logic              mem_rw;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_moc;

    // The controller: serves CPU requests and drives the RAM.
    modport slave (
        input  req_valid, req_rw, req_byte, req_signed, req_addr, req_wdata,
        input  mem_rdata, mem_moc,
        output busy, resp_valid, resp_err, resp_rdata,
        output mem_enable, mem_rw, mem_byte, mem_addr, mem_wdata
    );

    // The environment: control unit plus RAM.
    modport master (
        output req_valid, req_rw, req_byte, req_signed, req_addr, req_wdata,
        output mem_rdata, mem_moc,
        input  busy, resp_valid, resp_err, resp_rdata,
        input  mem_enable, mem_rw, mem_byte, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_controller_sync2.sv
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Two-flop synchronizer with a configurable reset value.
// Revision: 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_controller
// Brief   : Sequences single load/store requests onto the RAM MOC handshake;
//           optional access timeout enabled by defining MEM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_controller
    import memctl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = DEFAULT_MEM_BYTES,
    parameter int SETUP_CYCLES = 1
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  wire                     clk,
    input  wire                     reset,
    mem_access_controller_if.slave  bus
);
    localparam int c_ext_w = DATA_W - 8;

    state_t            r_state;
    logic              r_signed;
    logic [15:0]       r_cnt;
    logic              r_busy;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_mdr;
    logic              r_mem_enable;
    logic              r_mem_rw;
    logic              r_mem_byte;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_moc_s;
    logic [ADDR_W:0]   w_end;
    logic              w_reject;
    logic              w_timeout;
    logic [7:0]        w_rbyte;
    logic [DATA_W-1:0] w_capture;

    sync2 #(.RESET_VAL(1'b1)) u_moc_sync (
        .clk (clk),
        .rst (reset),
        .i_d (bus.mem_moc),
        .o_q (w_moc_s)
    );

    // One extra address bit so addr+size cannot wrap past the range check.
    assign w_end    = {1'b0, bus.req_addr} + (ADDR_W+1)'(access_size(bus.req_byte));
    assign w_reject = ((bus.req_byte == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
                    || (w_end > (ADDR_W+1)'(MEM_BYTES));

    assign w_rbyte   = bus.mem_rdata[7:0];
    assign w_capture = (r_mem_byte == SIZE_BYTE)
                     ? {{c_ext_w{w_rbyte[7] & r_signed}}, w_rbyte}
                     : bus.mem_rdata;

`ifdef MEM_TIMEOUT_EN
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_signed     <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mdr        <= '0;
            r_mem_enable <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_byte   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_mem_rw    <= bus.req_rw;
                        r_mem_byte  <= bus.req_byte;
                        r_mem_addr  <= bus.req_addr;
                        r_mem_wdata <= bus.req_wdata;
                        r_signed    <= bus.req_signed;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_resp_err  <= w_reject;
                        r_state     <= w_reject ? RESP : SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == 16'(SETUP_CYCLES - 1)) begin
                        r_cnt        <= '0;
                        r_mem_enable <= 1'b1;
                        r_state      <= ENABLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ENABLE: begin
                    r_state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (!w_moc_s) begin
                        r_state <= WAIT_HIGH;
                    end else if (w_timeout) begin
                        r_mem_enable <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WAIT_HIGH: begin
                    r_cnt <= r_cnt + 16'd1;
                    // A stale-low MOC must still go high again before completion.
                    if (w_moc_s) begin
                        r_mem_enable <= 1'b0;
                        if (r_mem_rw == MEM_READ) begin
                            r_mdr <= w_capture;
                        end
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_mem_enable <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_mdr;
    assign bus.mem_enable = r_mem_enable;
    assign bus.mem_rw     = r_mem_rw;
    assign bus.mem_byte   = r_mem_byte;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_controller
// Brief   : Randomized scoreboard bench with a byte-array RAM and MOC model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_controller;
    import memctl_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_access_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_controller #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_BYTES   (MEM_BYTES),
        .SETUP_CYCLES(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          issue_cyc;
        int          acc_before;
        int          exp_acc;
        bit          timed;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accesses = 0;
    int          min_lo   = 1;
    bit          ram_stuck = 1'b0;
    bit          ram_busy  = 1'b0;
    logic [7:0]  ram  [MEM_BYTES];
    logic [7:0]  refm [MEM_BYTES];
    logic [31:0] ref_mdr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic hold_chk(input logic [31:0] a, input logic [31:0] wd, input logic rw, input logic bt);
        if (!reset && bus.mem_enable === 1'b1) begin
            check("hold_addr", bus.mem_addr, a);
            check("hold_wdata", bus.mem_wdata, wd);
            check("hold_rw_byte", {30'd0, bus.mem_rw, bus.mem_byte}, {30'd0, rw, bt});
        end
    endtask

    // RAM model: big-endian words, byte reads return junk above bit 7.
    initial begin : ram_model
        bus.mem_moc   = 1'b1;
        bus.mem_rdata = '0;
        forever begin : ram_cycle
            logic [31:0] a, wd, junk;
            logic        rw, bt;
            int          lo, n;
            @(negedge clk);
            if (!reset && bus.mem_enable === 1'b1) begin
                ram_busy = 1'b1;
                accesses++;
                a  = bus.mem_addr;
                wd = bus.mem_wdata;
                rw = bus.mem_rw;
                bt = bus.mem_byte;
                if (ram_stuck) begin
                    n = 0;
                    while (bus.mem_enable === 1'b1 && n < 300) begin
                        @(negedge clk);
                        n++;
                    end
                    check("stuck_enable_release", {31'd0, bus.mem_enable}, 32'd0);
                end else begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        hold_chk(a, wd, rw, bt);
                    end
                    bus.mem_moc = 1'b0;
                    lo = $urandom_range(min_lo, min_lo + 3);
                    repeat (lo) begin
                        @(negedge clk);
                        if (!reset) check("enable_during_moc_low", {31'd0, bus.mem_enable}, 32'd1);
                        hold_chk(a, wd, rw, bt);
                    end
                    check("ram_addr_in_range", {31'd0, (longint'(a) + (bt ? 1 : 4)) <= MEM_BYTES}, 32'd1);
                    if ((longint'(a) + (bt ? 1 : 4)) <= MEM_BYTES) begin
                        if (rw == MEM_WRITE) begin
                            if (bt) ram[a] = wd[7:0];
                            else begin
                                ram[a]   = wd[31:24];
                                ram[a+1] = wd[23:16];
                                ram[a+2] = wd[15:8];
                                ram[a+3] = wd[7:0];
                            end
                        end else begin
                            junk = $urandom;
                            if (bt) bus.mem_rdata = {junk[31:8], ram[a]};
                            else    bus.mem_rdata = {ram[a], ram[a+1], ram[a+2], ram[a+3]};
                        end
                    end
                    bus.mem_moc = 1'b1;
                    n = 0;
                    while (bus.mem_enable === 1'b1 && n < 12) begin
                        @(negedge clk);
                        hold_chk(a, wd, rw, bt);
                        n++;
                    end
                    if (bus.mem_enable === 1'b1) check("enable_fall", {31'd0, bus.mem_enable}, 32'd0);
                end
                ram_busy = 1'b0;
            end
        end
    end

    // Response monitor: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("ram_access_count", accesses - e.acc_before, e.exp_acc);
                if (e.timed) check("err_latency", cyc - e.issue_cyc, 32'd2);
            end
        end
    end

    task automatic issue(input logic rw, input logic bt, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit push, input bit tmo);
        exp_t        e;
        int          n;
        logic [7:0]  b;
        longint      end_a;
        @(negedge clk);
        n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("busy_timeout", {31'd0, bus.busy}, 32'd0);
        end_a     = longint'(addr) + (bt ? 1 : 4);
        e.err     = ((!bt && addr[1:0] != 2'b00) || end_a > MEM_BYTES);
        e.exp_acc = e.err ? 0 : 1;
        e.timed   = e.err;
        if (tmo) begin
            e.err     = 1'b1;
            e.exp_acc = 1;
            e.timed   = 1'b0;
            e.rdata   = ref_mdr;
        end else if (e.err) begin
            e.rdata = ref_mdr;
        end else if (rw == MEM_WRITE) begin
            if (bt) refm[addr] = wd[7:0];
            else begin
                refm[addr]   = wd[31:24];
                refm[addr+1] = wd[23:16];
                refm[addr+2] = wd[15:8];
                refm[addr+3] = wd[7:0];
            end
            e.rdata = ref_mdr;
        end else begin
            if (bt) begin
                b = refm[addr];
                ref_mdr = sg ? {{24{b[7]}}, b} : {24'd0, b};
            end else begin
                ref_mdr = {refm[addr], refm[addr+1], refm[addr+2], refm[addr+3]};
            end
            e.rdata = ref_mdr;
        end
        e.issue_cyc  = cyc;
        e.acc_before = accesses;
        if (push) sb.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_rw     = rw;
        bus.req_byte   = bt;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic random_txn();
        logic        rw, bt, sg;
        logic [31:0] addr;
        rw = 1'($urandom_range(0, 1));
        bt = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) begin
            addr = $urandom_range(0, MEM_BYTES - 1);
            if (!bt && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        end else begin
            addr = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 8);
        end
        issue(rw, bt, sg, addr, $urandom, 1'b1, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bus.req_valid  = 1'b0;
        bus.req_rw     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            ram[i]  = 8'($urandom);
            refm[i] = ram[i];
        end
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_ctl", {29'd0, bus.mem_enable, bus.mem_rw, bus.mem_byte}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;

        // Directed accesses: word, signed/unsigned byte, write-then-read, rejects.
        issue(MEM_WRITE, SIZE_WORD, 1'b0, 32'h0,   32'h8C220004, 1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
        issue(MEM_WRITE, SIZE_BYTE, 1'b0, 32'h5,   32'h123456F0, 1'b1, 1'b0);
        issue(MEM_READ,  SIZE_BYTE, 1'b1, 32'h5,   32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_BYTE, 1'b0, 32'h5,   32'h0,        1'b1, 1'b0);
        issue(MEM_WRITE, SIZE_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h6,   32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h1FE, 32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h1FC, 32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_WORD, 1'b0, 32'h200, 32'h0,        1'b1, 1'b0);
        issue(MEM_READ,  SIZE_BYTE, 1'b1, 32'h1FF, 32'h0,        1'b1, 1'b0);
        issue(MEM_WRITE, SIZE_BYTE, 1'b0, 32'h200, 32'hA5,       1'b1, 1'b0);
        drain();
        check("literal_word_0", {refm[0], refm[1], refm[2], refm[3]}, 32'h8C220004);

        for (int i = 0; i < 60; i++) random_txn();
        drain();

        // Reset while the controller waits for MOC to return high.
        min_lo = 6;
        issue(MEM_READ, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (bus.mem_moc !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("moc_started", {31'd0, bus.mem_moc}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_enable", {31'd0, bus.mem_enable}, 32'd0);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        n = 0;
        while ((ram_busy || bus.mem_moc !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset   = 1'b0;
        ref_mdr = '0;
        min_lo  = 1;
        issue(MEM_READ, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) random_txn();
        drain();

`ifdef MEM_TIMEOUT_EN
        ram_stuck = 1'b1;
        issue(MEM_READ, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        drain();
        ram_stuck = 1'b0;
        issue(MEM_READ, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drain();
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
Sequencer between the CPU control unit and the byte-addressed RAM; it sits directly upstream of the RAM.
- Accepts one load/store request at a time and drives the RAM's memEnable/rw/byte/address/dataIn.
- Tracks the RAM's MOC completion handshake, latches read data into an MDR and returns a one-cycle response to the control unit.
- Performs alignment/range checks and byte sign-extension.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed to a 4-byte word).
- MEM_BYTES, 512, RAM size in bytes; used for range checking.
- SETUP_CYCLES, 1, cycles address/data are held stable before memEnable rises (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe; sampled only in IDLE
- req_rw  in  1  0=read, 1=write
- req_byte  in  1  1=byte access, 0=word access
- req_signed  in  1  byte reads only: sign-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data; byte stores use [7:0]
- busy  out  1  high whenever state is not IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid; request rejected
- resp_rdata  out  DATA_W  MDR contents; valid with resp_valid on reads
- mem_enable  out  1  to RAM memEnable
- mem_rw  out  1  to RAM rw
- mem_byte  out  1  to RAM byte
- mem_addr  out  ADDR_W  to RAM address
- mem_wdata  out  DATA_W  to RAM dataIn
- mem_rdata  in  DATA_W  from RAM output_destination
- mem_moc  in  1  from RAM MOC (idle high, low while the operation is in progress)

Behaviour:
- Reset values: all outputs 0 (busy, resp_*, mem_*, MDR); state IDLE; MOC synchronizer flops preset to 1.
- mem_moc passes through a 2-flop synchronizer; moc_s denotes the synchronized value.
- IDLE:
  - On req_valid, latch all req_* fields.
  - If the word address is misaligned (addr[1:0]!=0), or addr+size > MEM_BYTES: go to RESP with err=1; no RAM access.
  - Otherwise go to SETUP.
  - mem_addr, mem_rw, mem_byte and mem_wdata are driven from the latched fields starting the cycle after acceptance.
- SETUP: hold the mem_* fields for SETUP_CYCLES, then go to ENABLE.
- ENABLE: mem_enable=1, kept high through WAIT_LOW; go to WAIT_LOW.
- WAIT_LOW: remain until moc_s==0 (RAM has started), then go to WAIT_HIGH.
- WAIT_HIGH:
  - Remain until moc_s==1.
  - On that cycle: deassert mem_enable, and on a read capture mem_rdata into the MDR.
  - Then go to RESP.
- MDR capture rules:
  - Word read: MDR = mem_rdata.
  - Byte read: MDR = {24{b7 & req_signed}, b7..b0}.
  - Write: MDR unchanged; resp_rdata reports the previous MDR.
- RESP: resp_valid=1 for exactly one cycle, resp_err as determined; return to IDLE. A new request is accepted on the IDLE cycle after RESP, so there is no back-to-back acceptance.
- mem_* fields stay stable from SETUP until the cycle after mem_enable falls. They are not changed during WAIT_*.
- busy=1 in every state except IDLE. req_valid while busy is ignored; no queueing.
- If MOC is already low when ENABLE is entered (stale), WAIT_LOW proceeds as normal; WAIT_HIGH still requires the low-to-high transition.
- Reset mid-operation: immediate return to IDLE; mem_enable drops asynchronously; no response pulse is issued.

Optional Feature:
- MEM_TIMEOUT_EN
- Defined:
  - Parameter TIMEOUT_CYCLES (default 64) and an 8-bit-or-wider counter, cleared on entry to ENABLE and counting in WAIT_LOW/WAIT_HIGH.
  - Reaching TIMEOUT_CYCLES deasserts mem_enable, goes to RESP with err=1, and leaves the MDR unchanged.
- Undefined: no counter; the controller waits indefinitely for MOC.

Decomposition:
- Shared package memctl_pkg:
  - State enum (IDLE, SETUP, ENABLE, WAIT_LOW, WAIT_HIGH, RESP).
  - Access-size constants (SIZE_WORD=0, SIZE_BYTE=1).
  - RW constants (MEM_READ=0, MEM_WRITE=1).
  - Default MEM_BYTES.
- One natural sub-module: sync2 (2-flop synchronizer with preset value), used for mem_moc.

Test Plan:
1. Word read: addr=0x0, RAM word 0x8C220004 -> mem_enable high for the full MOC low period; resp_valid one cycle with rdata=0x8C220004, err=0.
2. Signed byte read: addr=0x5, byte=0xF0, signed=1 -> rdata=0xFFFFFFF0; same access with signed=0 -> 0x000000F0.
3. Word write: addr=0x10, wdata=0xDEADBEEF -> mem_rw=1 and mem_wdata stable until mem_enable falls; a following read returns 0xDEADBEEF.
4. Misaligned/out of range: word read at addr=0x6, then at addr=0x1FE -> resp_err=1 two cycles after req_valid; mem_enable never asserted.
5. Reset asserted during WAIT_HIGH -> mem_enable=0 immediately, busy=0, no resp_valid; a new request after reset completes normally.
6. MEM_TIMEOUT_EN with MOC stuck high -> resp_err=1 exactly TIMEOUT_CYCLES after ENABLE, mem_enable=0, MDR unchanged.
